// File: rtl/la_dispatch_pkg.sv
// Shared types and command bytes for the task sequencer and its watchdog.
// Command values are the ASCII bytes delivered by the UART receiver.
package la_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_CONT   = 1'b0,
    MODE_SINGLE = 1'b1
  } mode_e;

  localparam logic [7:0] CMD_START  = 8'h67;  // 'g'
  localparam logic [7:0] CMD_SINGLE = 8'h31;  // '1'
  localparam logic [7:0] CMD_STOP   = 8'h73;  // 's'
  localparam logic [7:0] CMD_ABORT  = 8'h62;  // 'b'

endpackage

// File: rtl/task_watchdog.sv
// Saturating cycle counter that flags a grant held for TIMEOUT_CYCLES cycles.
// Combinational expired output, no backpressure; TIMEOUT_CYCLES=0 disables it.
module task_watchdog #(
  parameter int TIMEOUT_W      = 24,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q >= LIMIT);

endmodule

// File: rtl/task_sequencer.sv
// UART-commanded round-robin scheduler granting one worker task at a time.
// Start -> grant next cycle; done -> one idle GAP cycle -> next grant.
module task_sequencer
  import la_dispatch_pkg::*;
#(
  parameter int  NUM_TASKS      = 2,
  parameter int  TIMEOUT_W      = 24,
  parameter int  TIMEOUT_CYCLES = 0,
  parameter int  PASS_W         = 16,
  localparam int TW             = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_data_fresh,
  input  logic [NUM_TASKS-1:0] done,
  output logic [NUM_TASKS-1:0] grant,
  output logic [TW-1:0]        cur_task,
  output logic                 busy,
  output logic                 led,
  output logic                 timeout_err,
  output logic [PASS_W-1:0]    pass_count
);

  localparam logic [TW-1:0] LAST_IDX = TW'(NUM_TASKS - 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [TW-1:0]        cur_q, cur_d;
  logic                 stop_q, stop_d;
  logic                 terr_q, terr_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  logic [NUM_TASKS-1:0] grant_q, grant_d;

  logic cmd_start, cmd_single, cmd_stop, cmd_abort;
  logic wd_expired, completion, last_task;

  assign cmd_start  = rx_data_fresh && (rx_data == CMD_START);
  assign cmd_single = rx_data_fresh && (rx_data == CMD_SINGLE);
  assign cmd_stop   = rx_data_fresh && (rx_data == CMD_STOP);
  assign cmd_abort  = rx_data_fresh && (rx_data == CMD_ABORT);

  task_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_RUN),
    .enable  (state_q == ST_RUN),
    .expired (wd_expired)
  );

  assign last_task  = (cur_q == LAST_IDX);
  assign completion = (state_q == ST_RUN) && (done[cur_q] || wd_expired);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    stop_d  = stop_q;
    terr_d  = terr_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start || cmd_single) begin
          state_d = ST_RUN;
          cur_d   = '0;
          mode_d  = cmd_single ? MODE_SINGLE : MODE_CONT;
          stop_d  = 1'b0;
          terr_d  = 1'b0;
          pass_d  = '0;
        end
      end
      ST_RUN: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end else if (completion) begin
          if (wd_expired) terr_d = 1'b1;
          if (last_task) pass_d = pass_q + PASS_W'(1);
          // A stop arriving with the completing done takes effect right here.
          if ((last_task && mode_q == MODE_SINGLE) || stop_q || cmd_stop) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = ST_GAP;
          end
        end else if (cmd_stop) begin
          stop_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
          cur_d   = last_task ? '0 : cur_q + TW'(1);
          if (cmd_stop) stop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    grant_d = '0;
    if (state_d == ST_RUN) grant_d[cur_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_CONT;
      cur_q   <= '0;
      stop_q  <= 1'b0;
      terr_q  <= 1'b0;
      pass_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      stop_q  <= stop_d;
      terr_q  <= terr_d;
      pass_q  <= pass_d;
      grant_q <= grant_d;
    end
  end

  assign grant       = grant_q;
  assign cur_task    = cur_q;
  assign busy        = (state_q != ST_IDLE);
  assign led         = busy;
  assign timeout_err = terr_q;
  assign pass_count  = pass_q;

endmodule

// File: tb/tb_task_sequencer.sv
// Bench for task_sequencer: directed vector table, hand sequences for watchdog
// and pass-count wrap, then random commands checked against a scheduling model.
module tb_task_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_fresh;
  logic [2:0] done3;
  logic [0:0] done1;

  logic [2:0] grant3;
  logic [1:0] cur3;
  logic       busy3, led3, terr3;
  logic [3:0] pass3;
  logic [0:0] grant1;
  logic [0:0] cur1;
  logic       busy1, led1, terr1;
  logic [3:0] pass1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task_sequencer #(.NUM_TASKS(3), .TIMEOUT_W(8), .TIMEOUT_CYCLES(10), .PASS_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_fresh(rx_data_fresh), .done(done3),
    .grant(grant3), .cur_task(cur3), .busy(busy3), .led(led3),
    .timeout_err(terr3), .pass_count(pass3)
  );

  task_sequencer #(.NUM_TASKS(1), .TIMEOUT_W(8), .TIMEOUT_CYCLES(0), .PASS_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_fresh(rx_data_fresh), .done(done1),
    .grant(grant1), .cur_task(cur1), .busy(busy1), .led(led1),
    .timeout_err(terr1), .pass_count(pass1)
  );

  // Scheduler state as the rules describe it: running or not, sitting in the
  // inter-task gap or not, which task, and cycles since that task's grant.
  typedef struct {
    bit running;
    bit gap;
    bit single;
    bit stop;
    bit terr;
    int idx;
    int pass;
    int wd;
  } model_t;

  model_t m3, m1;

  function automatic model_t step(model_t m, int n, int tmo, bit r, bit f,
                                  logic [7:0] d, logic [2:0] dn);
    model_t s;
    bit c_go, c_one, c_stop, c_abort, fired, fin, last;
    s = m;
    if (r) begin
      s = '{default: 0};
      return s;
    end
    c_go    = f && (d == 8'h67);
    c_one   = f && (d == 8'h31);
    c_stop  = f && (d == 8'h73);
    c_abort = f && (d == 8'h62);
    if (!m.running) begin
      if (c_go || c_one) begin
        s.running = 1; s.gap = 0; s.idx = 0; s.terr = 0; s.pass = 0;
        s.single = c_one; s.stop = 0; s.wd = 0;
      end
    end else if (c_abort) begin
      s.running = 0; s.gap = 0; s.stop = 0;
    end else if (m.gap) begin
      s.gap = 0;
      s.idx = (m.idx + 1) % n;
      s.wd  = 0;
      if (c_stop) s.stop = 1;
    end else begin
      fired = (tmo != 0) && (m.wd >= tmo);
      fin   = dn[m.idx] || fired;
      last  = (m.idx == n - 1);
      if (fin) begin
        if (fired) s.terr = 1;
        if (last) s.pass = (m.pass + 1) % 16;
        if ((last && m.single) || m.stop || c_stop) begin
          s.running = 0; s.stop = 0;
        end else begin
          s.gap = 1;
        end
      end else begin
        s.wd = m.wd + 1;
        if (c_stop) s.stop = 1;
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_grant(model_t m);
    return (m.running && !m.gap) ? (32'd1 << m.idx) : 32'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp_models();
    chk("m3_grant", 32'(grant3), exp_grant(m3));
    chk("m3_cur",   32'(cur3),   32'(m3.idx));
    chk("m3_busy",  32'(busy3),  32'(m3.running));
    chk("m3_led",   32'(led3),   32'(m3.running));
    chk("m3_terr",  32'(terr3),  32'(m3.terr));
    chk("m3_pass",  32'(pass3),  32'(m3.pass));
    chk("m1_grant", 32'(grant1), exp_grant(m1));
    chk("m1_cur",   32'(cur1),   32'(m1.idx));
    chk("m1_busy",  32'(busy1),  32'(m1.running));
    chk("m1_led",   32'(led1),   32'(m1.running));
    chk("m1_terr",  32'(terr1),  32'(m1.terr));
    chk("m1_pass",  32'(pass1),  32'(m1.pass));
  endtask

  task automatic tick();
    @(posedge clk);
    m3 = step(m3, 3, 10, rst, rx_data_fresh, rx_data, done3);
    m1 = step(m1, 1, 0, rst, rx_data_fresh, rx_data, {2'b00, done1});
    #1;
    cmp_models();
  endtask

  task automatic drive(input bit r, input bit f, input logic [7:0] d,
                       input logic [2:0] dn3, input logic dn1);
    rst = r; rx_data_fresh = f; rx_data = d; done3 = dn3; done1 = dn1;
  endtask

  typedef struct {
    bit         r;
    bit         f;
    logic [7:0] d;
    logic [2:0] dn;
    logic [2:0] g;
    logic [1:0] c;
    bit         b;
    bit         t;
    logic [3:0] p;
  } vec_t;

  function automatic vec_t mk(bit r, bit f, logic [7:0] d, logic [2:0] dn,
                              logic [2:0] g, logic [1:0] c, bit b, bit t, logic [3:0] p);
    vec_t v;
    v.r = r; v.f = f; v.d = d; v.dn = dn; v.g = g; v.c = c; v.b = b; v.t = t; v.p = p;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   cnt;
    int   sel;

    m3 = '{default: 0};
    m1 = '{default: 0};
    drive(1, 0, 8'h00, 3'b000, 1'b0);

    //             rst f  data   done    grant  cur b  t  pass
    tbl.push_back(mk(1, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h67, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h41, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h73, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h67, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b010, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b001, 3'b000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b001, 3'b010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h67, 3'b000, 3'b010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b010, 3'b000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b100, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b100, 3'b000, 2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 8'h73, 3'b000, 3'b001, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b001, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 3'b001, 3'b000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h31, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h62, 3'b001, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b001, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h67, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h73, 3'b001, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h31, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b001, 3'b000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b010, 3'b000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b100, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b100, 3'b000, 2, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 3'b100, 3'b000, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h67, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 8'h67, 3'b001, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h67, 3'b000, 3'b001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b001, 3'b000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h73, 3'b000, 3'b010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b010, 3'b000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 3'b000, 3'b000, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].d, tbl[i].dn, 1'b0);
      tick();
      chk($sformatf("tbl%0d_grant", i), 32'(grant3), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_cur", i),   32'(cur3),   32'(tbl[i].c));
      chk($sformatf("tbl%0d_busy", i),  32'(busy3),  32'(tbl[i].b));
      chk($sformatf("tbl%0d_terr", i),  32'(terr3),  32'(tbl[i].t));
      chk($sformatf("tbl%0d_pass", i),  32'(pass3),  32'(tbl[i].p));
    end

    // Watchdog: task 0 never finishes; grant is held from t through t+10.
    drive(0, 1, 8'h67, 3'b000, 1'b0);
    tick();
    drive(0, 0, 8'h00, 3'b000, 1'b0);
    cnt = (grant3 == 3'b001) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (grant3 == 3'b001) cnt++;
      else break;
    end
    chk("wd_grant_cycles", 32'(cnt), 32'd11);
    chk("wd_terr_set", 32'(terr3), 32'd1);
    tick();
    chk("wd_next_task", 32'(grant3), 32'b010);
    drive(0, 1, 8'h62, 3'b000, 1'b0);
    tick();
    drive(0, 1, 8'h67, 3'b000, 1'b0);
    tick();
    chk("wd_terr_cleared", 32'(terr3), 32'd0);

    // Single-task instance: done held high completes every other cycle;
    // 40 cycles give 20 passes, which wraps the 4-bit counter to 4.
    drive(1, 0, 8'h00, 3'b000, 1'b0);
    tick();
    drive(0, 1, 8'h67, 3'b000, 1'b0);
    tick();
    drive(0, 0, 8'h00, 3'b000, 1'b1);
    for (int k = 0; k < 40; k++) tick();
    chk("one_task_pass_wrap", 32'(pass1), 32'd4);
    chk("one_task_regrant", 32'(grant1), 32'd1);

    for (int k = 0; k < 4000; k++) begin
      rst           = ($urandom_range(0, 199) == 0);
      rx_data_fresh = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 99);
      if (sel < 30)      rx_data = 8'h67;
      else if (sel < 40) rx_data = 8'h31;
      else if (sel < 48) rx_data = 8'h73;
      else if (sel < 55) rx_data = 8'h62;
      else               rx_data = 8'($urandom_range(0, 255));
      for (int b = 0; b < 3; b++) done3[b] = ($urandom_range(0, 4) == 0);
      done1[0] = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
